// File: rtl/direct_mapped_cache_if.sv
// direct_mapped_cache_if: processor-side and RAM-side handshake bundle of the cache
`timescale 1ns/1ps
interface direct_mapped_cache_if;
  logic        ProzessorLesen;
  logic        ProzessorSchreiben;
  logic [31:0] ProzessorAdresse;
  logic [31:0] ProzessorSchreibDaten;
  logic [31:0] ProzessorLesDaten;
  logic        ProzessorDatenGelesen;
  logic        ProzessorDatenGeschrieben;
  logic        RAMLesen;
  logic        RAMSchreiben;
  logic [31:0] RAMAdresse;
  logic [31:0] RAMSchreibDaten;
  logic [31:0] RAMLesDaten;
  logic        RAMDatenGelesen;
  logic        RAMDatenGeschrieben;
  modport slave (
    input  ProzessorLesen, ProzessorSchreiben, ProzessorAdresse, ProzessorSchreibDaten,
           RAMLesDaten, RAMDatenGelesen, RAMDatenGeschrieben,
    output ProzessorLesDaten, ProzessorDatenGelesen, ProzessorDatenGeschrieben,
           RAMLesen, RAMSchreiben, RAMAdresse, RAMSchreibDaten
  );
  modport master (
    output ProzessorLesen, ProzessorSchreiben, ProzessorAdresse, ProzessorSchreibDaten,
           RAMLesDaten, RAMDatenGelesen, RAMDatenGeschrieben,
    input  ProzessorLesDaten, ProzessorDatenGelesen, ProzessorDatenGeschrieben,
           RAMLesen, RAMSchreiben, RAMAdresse, RAMSchreibDaten
  );
endinterface

// File: rtl/direct_mapped_cache.sv
// direct_mapped_cache: write-through, no-write-allocate direct-mapped cache with block refill
`timescale 1ns/1ps
module direct_mapped_cache #(
  parameter int CACHESIZEBITS = 15,
  parameter int BLOCKSIZEBITS = 2
) (
  input logic                  Clock,
  input logic                  Reset,
  direct_mapped_cache_if.slave bus
);
  localparam int IW    = CACHESIZEBITS - BLOCKSIZEBITS;
  localparam int TW    = 32 - CACHESIZEBITS;
  localparam int LINES = 1 << IW;
  localparam int WORDS = 1 << CACHESIZEBITS;
  typedef enum logic [2:0] {IDLE, FILL_REQ, FILL_WAIT, WRITE_REQ, WRITE_WAIT, DONE} state_t;
  logic [31:0]              data_mem [WORDS];
  logic [TW-1:0]            tag_mem [LINES];
  logic [LINES-1:0]         valid_q;
  state_t                   state_q, state_d;
  logic [BLOCKSIZEBITS-1:0] cnt_q, cnt_d;
  logic                     rd_ack_q, rd_ack_d, wr_ack_q, wr_ack_d, ram_rd_q, ram_rd_d, ram_wr_q, ram_wr_d;
  logic [31:0]              ram_addr_q, ram_addr_d, ram_wdata_q, ram_wdata_d, rdata_q, rdata_d;
  logic [IW-1:0]            idx;
  logic [TW-1:0]            tag;
  logic                     hit, data_we, tag_we, valid_set, valid_clr;
  logic [CACHESIZEBITS-1:0] data_wa;
  logic [31:0]              data_wd;
  assign idx = bus.ProzessorAdresse[CACHESIZEBITS-1:BLOCKSIZEBITS];
  assign tag = bus.ProzessorAdresse[31:CACHESIZEBITS];
  assign hit = valid_q[idx] && tag_mem[idx] == tag;
  assign bus.ProzessorLesDaten         = rdata_q;
  assign bus.ProzessorDatenGelesen     = rd_ack_q;
  assign bus.ProzessorDatenGeschrieben = wr_ack_q;
  assign bus.RAMLesen                  = ram_rd_q;
  assign bus.RAMSchreiben              = ram_wr_q;
  assign bus.RAMAdresse                = ram_addr_q;
  assign bus.RAMSchreibDaten           = ram_wdata_q;
  // next state, next registered outputs and array write strobes
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rd_ack_d    = rd_ack_q;
    wr_ack_d    = wr_ack_q;
    ram_rd_d    = ram_rd_q;
    ram_wr_d    = ram_wr_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    rdata_d     = rdata_q;
    data_we     = 1'b0;
    data_wa     = bus.ProzessorAdresse[CACHESIZEBITS-1:0];
    data_wd     = bus.RAMLesDaten;
    tag_we      = 1'b0;
    valid_set   = 1'b0;
    valid_clr   = 1'b0;
    case (state_q)
      IDLE:
        if (bus.ProzessorSchreiben) state_d = WRITE_REQ;
        else if (bus.ProzessorLesen && hit) begin
          rdata_d  = data_mem[bus.ProzessorAdresse[CACHESIZEBITS-1:0]];
          rd_ack_d = 1'b1;
          state_d  = DONE;
        end else if (bus.ProzessorLesen) begin
          valid_clr = 1'b1;
          cnt_d     = '0;
          state_d   = FILL_REQ;
        end
      FILL_REQ:
        if (!bus.RAMDatenGelesen) begin
          ram_rd_d   = 1'b1;
          ram_addr_d = {tag, idx, cnt_q};
          state_d    = FILL_WAIT;
        end
      FILL_WAIT:
        if (bus.RAMDatenGelesen) begin
          ram_rd_d  = 1'b0;
          data_we   = 1'b1;
          data_wa   = {idx, cnt_q};
          tag_we    = cnt_q == '1;
          valid_set = cnt_q == '1;
          cnt_d     = cnt_q + BLOCKSIZEBITS'(1);
          state_d   = cnt_q == '1 ? IDLE : FILL_REQ;
        end
      WRITE_REQ: begin
        ram_wr_d    = 1'b1;
        ram_addr_d  = bus.ProzessorAdresse;
        ram_wdata_d = bus.ProzessorSchreibDaten;
        state_d     = WRITE_WAIT;
      end
      WRITE_WAIT:
        if (bus.RAMDatenGeschrieben) begin
          ram_wr_d = 1'b0;
          data_we  = hit;
          data_wd  = bus.ProzessorSchreibDaten;
          wr_ack_d = 1'b1;
          state_d  = DONE;
        end
      DONE:
        if (!bus.ProzessorLesen && !bus.ProzessorSchreiben) begin
          rd_ack_d = 1'b0;
          wr_ack_d = 1'b0;
          rdata_d  = '0;
          state_d  = IDLE;
        end
      default: state_d = IDLE;
    endcase
  end
  // control state, valid bits and registered outputs
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      valid_q     <= '0;
      rd_ack_q    <= 1'b0;
      wr_ack_q    <= 1'b0;
      ram_rd_q    <= 1'b0;
      ram_wr_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rd_ack_q    <= rd_ack_d;
      wr_ack_q    <= wr_ack_d;
      ram_rd_q    <= ram_rd_d;
      ram_wr_q    <= ram_wr_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      rdata_q     <= rdata_d;
      if (valid_clr) valid_q[idx] <= 1'b0;
      else if (valid_set) valid_q[idx] <= 1'b1;
    end
  end
  // data and tag arrays carry no reset; the valid bits alone qualify them
  always_ff @(posedge Clock) begin
    if (data_we) data_mem[data_wa] <= data_wd;
    if (tag_we) tag_mem[idx] <= tag;
  end
endmodule

// File: tb/tb_direct_mapped_cache.sv
// tb_direct_mapped_cache: table-driven scoreboard bench with a 1-cycle-latency RAM model
`timescale 1ns/1ps
module tb_direct_mapped_cache;
  logic Clock = 1'b0;
  logic Reset = 1'b0;
  always #5 Clock = ~Clock;
  direct_mapped_cache_if bus();
  direct_mapped_cache dut (.Clock(Clock), .Reset(Reset), .bus(bus));
  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    bit          fill;
  } vec_t;
  int          n_cmp = 0;
  int          n_err = 0;
  int          rd_seen = 0;
  int          wr_seen = 0;
  logic [31:0] mem [logic [31:0]];
  logic [31:0] exp_rd_q [$];
  logic [63:0] exp_wr_q [$];
  logic [31:0] exp_dat_q [$];
  function automatic logic [31:0] ram_val(logic [31:0] a);
    return mem.exists(a) ? mem[a] : a + 32'h100;
  endfunction
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  // RAM model: acknowledge follows request one cycle later, drops one cycle after it
  always @(posedge Clock) begin
    if (!Reset) begin
      bus.RAMDatenGelesen     <= 1'b0;
      bus.RAMDatenGeschrieben <= 1'b0;
      bus.RAMLesDaten         <= '0;
    end else begin
      bus.RAMDatenGelesen     <= bus.RAMLesen;
      bus.RAMDatenGeschrieben <= bus.RAMSchreiben;
      if (bus.RAMLesen && !bus.RAMDatenGelesen) begin
        rd_seen++;
        bus.RAMLesDaten <= ram_val(bus.RAMAdresse);
        if (exp_rd_q.size() != 0) chk("ram_read_addr", bus.RAMAdresse, exp_rd_q.pop_front());
      end
      if (bus.RAMSchreiben && !bus.RAMDatenGeschrieben) begin
        logic [63:0] e;
        wr_seen++;
        mem[bus.RAMAdresse] = bus.RAMSchreibDaten;
        if (exp_wr_q.size() != 0) begin
          e = exp_wr_q.pop_front();
          chk("ram_write_addr", bus.RAMAdresse, e[63:32]);
          chk("ram_write_data", bus.RAMSchreibDaten, e[31:0]);
        end
      end
    end
  end
  task automatic check_outputs_zero(string name);
    chk({name, "_acks"}, {28'b0, bus.ProzessorDatenGelesen, bus.ProzessorDatenGeschrieben,
        bus.RAMLesen, bus.RAMSchreiben}, 32'h0);
    chk({name, "_ram_addr"}, bus.RAMAdresse, 32'h0);
    chk({name, "_ram_wdata"}, bus.RAMSchreibDaten, 32'h0);
    chk({name, "_rdata"}, bus.ProzessorLesDaten, 32'h0);
  endtask
  task automatic access(input vec_t v, input bit both);
    int n, r0, w0;
    bit got, stray;
    r0 = rd_seen;
    w0 = wr_seen;
    if (v.fill) for (int k = 0; k < 4; k++) exp_rd_q.push_back({v.addr[31:2], 2'(k)});
    if (v.wr) exp_wr_q.push_back({v.addr, v.wdata});
    else exp_dat_q.push_back(v.exp);
    @(posedge Clock); #1;
    bus.ProzessorAdresse      = v.addr;
    bus.ProzessorSchreibDaten = v.wdata;
    bus.ProzessorSchreiben    = v.wr;
    bus.ProzessorLesen        = !v.wr || both;
    n = 0;
    got = 1'b0;
    stray = 1'b0;
    while (!got && n < 200) begin
      @(posedge Clock); #1;
      n++;
      got = v.wr ? bus.ProzessorDatenGeschrieben : bus.ProzessorDatenGelesen;
      if (v.wr && bus.ProzessorDatenGelesen) stray = 1'b1;
    end
    chk("ack_seen", 32'(got), 32'h1);
    if (v.wr) chk("no_read_ack", 32'(stray), 32'h0);
    else begin
      chk("read_data", bus.ProzessorLesDaten, exp_dat_q.pop_front());
      if (!v.fill) chk("hit_latency", 32'(n), 32'h1);
    end
    chk("ram_reads", 32'(rd_seen - r0), v.fill ? 32'h4 : 32'h0);
    chk("ram_writes", 32'(wr_seen - w0), v.wr ? 32'h1 : 32'h0);
    bus.ProzessorLesen     = 1'b0;
    bus.ProzessorSchreiben = 1'b0;
    n = 0;
    while ((bus.ProzessorDatenGelesen || bus.ProzessorDatenGeschrieben) && n < 20) begin
      @(posedge Clock); #1;
      n++;
    end
    chk("ack_drop", {30'b0, bus.ProzessorDatenGelesen, bus.ProzessorDatenGeschrieben}, 32'h0);
    chk("queues_drained", 32'(exp_rd_q.size() + exp_wr_q.size()), 32'h0);
  endtask
  initial begin
    vec_t tbl [11];
    int n, r0;
    tbl = '{
      '{1'b0, 32'h0000_0010, 32'h0,         32'h0000_0110, 1'b1},
      '{1'b0, 32'h0000_0012, 32'h0,         32'h0000_0112, 1'b0},
      '{1'b1, 32'h0000_0012, 32'hDEAD_BEEF, 32'h0,         1'b0},
      '{1'b0, 32'h0000_0012, 32'h0,         32'hDEAD_BEEF, 1'b0},
      '{1'b0, 32'h0000_8010, 32'h0,         32'h0000_8110, 1'b1},
      '{1'b0, 32'h0000_0010, 32'h0,         32'h0000_0110, 1'b1},
      '{1'b0, 32'h0000_0013, 32'h0,         32'h0000_0113, 1'b0},
      '{1'b1, 32'h0000_0040, 32'h0000_0055, 32'h0,         1'b0},
      '{1'b0, 32'h0000_0040, 32'h0,         32'h0000_0055, 1'b1},
      '{1'b0, 32'hFFFF_FFFF, 32'h0,         32'h0000_00FF, 1'b1},
      '{1'b0, 32'h8000_0010, 32'h0,         32'h8000_0110, 1'b1}
    };
    bus.ProzessorLesen        = 1'b0;
    bus.ProzessorSchreiben    = 1'b0;
    bus.ProzessorAdresse      = '0;
    bus.ProzessorSchreibDaten = '0;
    repeat (2) @(posedge Clock);
    #1;
    check_outputs_zero("reset");
    Reset = 1'b1;
    foreach (tbl[i]) access(tbl[i], 1'b0);
    access('{1'b0, 32'hFFFF_FFFD, 32'h0, 32'h0000_00FD, 1'b0}, 1'b0);
    r0 = rd_seen;
    for (int k = 0; k < 4; k++) exp_rd_q.push_back(32'h20 + k);
    @(posedge Clock); #1;
    bus.ProzessorAdresse = 32'h20;
    bus.ProzessorLesen   = 1'b1;
    n = 0;
    while (rd_seen - r0 < 2 && n < 100) begin
      @(posedge Clock); #1;
      n++;
    end
    chk("midfill_progress", 32'(rd_seen - r0 >= 2), 32'h1);
    Reset = 1'b0;
    #1;
    check_outputs_zero("async_reset");
    bus.ProzessorLesen = 1'b0;
    exp_rd_q.delete();
    repeat (3) @(posedge Clock);
    #1;
    Reset = 1'b1;
    access('{1'b0, 32'h0000_0020, 32'h0, 32'h0000_0120, 1'b1}, 1'b0);
    access('{1'b1, 32'h0000_0030, 32'h0000_0077, 32'h0, 1'b0}, 1'b1);
    access('{1'b0, 32'h0000_0030, 32'h0, 32'h0000_0077, 1'b1}, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
